// File: rtl/hashpipe_msg_feeder_if.sv
// Message-feeder bus: block load handshake, run control and
// issued-block outputs toward the first schedule quad.
interface hashpipe_msg_feeder_if #(
  parameter int WORDBITS = 32,
  parameter int MSGWORDS = 16
) ();
  localparam int MSGBITS = MSGWORDS * WORDBITS;

  logic                load_valid;
  logic                load_ready;
  logic [WORDBITS-1:0] load_data;
  logic                load_last;
  logic                start;
  logic [WORDBITS-1:0] nonce_start;
  logic [WORDBITS-1:0] nonce_count;
  logic                hold;
  logic                stop;
  logic [MSGBITS-1:0]  W_out;
  logic                w_valid;
  logic [WORDBITS-1:0] issue_nonce;
  logic                busy;
  logic                done;
  logic                aborted;

  modport slave (
    input  load_valid, load_data, load_last,
    input  start, nonce_start, nonce_count,
    input  hold, stop,
    output load_ready, W_out, w_valid,
    output issue_nonce, busy, done, aborted
  );

  modport master (
    output load_valid, load_data, load_last,
    output start, nonce_start, nonce_count,
    output hold, stop,
    input  load_ready, W_out, w_valid,
    input  issue_nonce, busy, done, aborted
  );
endinterface

// File: rtl/hashpipe_msg_feeder.sv
// Loads one 16-word block, then issues it once per clock with a
// running nonce spliced into word NONCE_WORD.
module hashpipe_msg_feeder #(
  parameter int WORDBITS   = 32,
  parameter int MSGWORDS   = 16,
  parameter int MSGBITS    = MSGWORDS * WORDBITS,
  parameter int NONCE_WORD = 3
) (
  input logic clk,
  input logic rst_n,
  hashpipe_msg_feeder_if.slave bus
);
  localparam int IDXW = (MSGWORDS > 1) ? $clog2(MSGWORDS) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(MSGWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t              r_state;
  logic [WORDBITS-1:0] r_msg [MSGWORDS];
  logic                r_loaded;
  logic [IDXW-1:0]     r_idx;
  logic [WORDBITS-1:0] r_nonce;
  logic [WORDBITS-1:0] r_remain;
  logic [MSGBITS-1:0]  r_wout;
  logic                r_wvalid;
  logic [WORDBITS-1:0] r_inonce;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;

  logic                w_ready;
  logic                w_load;
  logic                w_start;
  logic [MSGBITS-1:0]  w_blk;

  assign w_ready = (r_state == S_IDLE);
  assign w_load  = bus.load_valid && w_ready;
  // Uses the registered flag: a same-cycle load_last cannot arm this start.
  assign w_start = w_ready && bus.start && r_loaded;

  always_comb begin
    w_blk = '0;
    for (int i = 0; i < MSGWORDS; i++) begin
      if (i == NONCE_WORD)
        w_blk[i*WORDBITS +: WORDBITS] = r_nonce;
      else
        w_blk[i*WORDBITS +: WORDBITS] = r_msg[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < MSGWORDS; i++)
        r_msg[i] <= '0;
      r_loaded  <= 1'b0;
      r_idx     <= '0;
      r_nonce   <= '0;
      r_remain  <= '0;
      r_wout    <= '0;
      r_wvalid  <= 1'b0;
      r_inonce  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_wvalid <= 1'b0;
      r_done   <= 1'b0;

      if (w_load) begin
        r_msg[r_idx] <= bus.load_data;
        if (bus.load_last) begin
          r_idx    <= '0;
          r_loaded <= 1'b1;
        end else if (r_idx == IDX_MAX) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_nonce   <= bus.nonce_start;
            r_remain  <= bus.nonce_count;
            r_aborted <= 1'b0;
            if (bus.nonce_count == '0) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Stop wins over hold and over the final block.
          if (bus.stop) begin
            r_state   <= S_FIN;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (!bus.hold) begin
            r_wout   <= w_blk;
            r_wvalid <= 1'b1;
            r_inonce <= r_nonce;
            r_nonce  <= r_nonce + WORDBITS'(1);
            r_remain <= r_remain - WORDBITS'(1);
            if (r_remain == WORDBITS'(1)) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = w_ready;
  assign bus.W_out       = r_wout;
  assign bus.w_valid     = r_wvalid;
  assign bus.issue_nonce = r_inonce;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;
endmodule
